div_unit: RTL and testbench

Multi-cycle 32-bit integer divider for the MIPS datapath, implementing the DIV/DIVU results that feed the HI/LO registers. It performs restoring division, one subtract-and-shift per clock, and reports results through a start/done handshake. The control unit stalls on `busy`. The block sits beside the combinational adder/ALU in the execute stage.

---
 rtl/div_pkg.sv | 17 +
 rtl/div_step.sv | 27 ++
 rtl/div_unit.sv | 115 +++++++++++
 tb/tb_div_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle restoring divider: default width,
// FSM state encoding and the iteration counter sizing helper.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // One extra bit so the counter can represent WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in the next dividend
// bit, trial-subtract the divisor magnitude, keep or restore.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor_mag,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0]   partial;
  logic [WIDTH-1:0] diff_lo;

  // The partial remainder is always below 2*divisor, so a non-negative
  // difference fits in WIDTH bits and the low-order subtraction is exact.
  always_comb begin
    partial = {rem_in, dividend_bit};
    q_bit   = (partial >= {1'b0, divisor_mag});
    diff_lo = partial[WIDTH-1:0] - divisor_mag;
    rem_out = q_bit ? diff_lo : partial[WIDTH-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit: start/done handshake, WIDTH restoring steps,
// then sign fix-up and a registered result held until the next division.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_width(WIDTH);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] dividend_cap;
  logic             neg_dividend;
  logic             neg_divisor;
  logic             dvz;

  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in      (rem_r),
    .dividend_bit(quo_r[WIDTH-1]),
    .divisor_mag (dvs_mag),
    .rem_out     (step_rem),
    .q_bit       (step_q)
  );

  assign busy = (state != S_IDLE);

  // quo_r starts as the dividend magnitude; its MSB feeds each step while
  // quotient bits shift in from the bottom. DONE lasts two cycles: the
  // first loads the outputs, the second carries the done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      rem_r        <= '0;
      quo_r        <= '0;
      dvs_mag      <= '0;
      dividend_cap <= '0;
      neg_dividend <= 1'b0;
      neg_divisor  <= 1'b0;
      dvz          <= 1'b0;
      done         <= 1'b0;
      quotient     <= '0;
      remainder    <= '0;
      div_by_zero  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            dividend_cap <= dividend;
            neg_dividend <= is_signed & dividend[WIDTH-1];
            neg_divisor  <= is_signed & divisor[WIDTH-1];
            quo_r        <= (is_signed & dividend[WIDTH-1]) ? -dividend : dividend;
            dvs_mag      <= (is_signed & divisor[WIDTH-1]) ? -divisor : divisor;
            dvz          <= (divisor == '0);
            rem_r        <= '0;
            cnt          <= '0;
            state        <= S_RUN;
          end
        end
        S_RUN: begin
          rem_r <= step_rem;
          quo_r <= {quo_r[WIDTH-2:0], step_q};
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          if (dvz) begin
            quo_r <= '1;
            rem_r <= dividend_cap;
          end else begin
            quo_r <= (neg_dividend ^ neg_divisor) ? -quo_r : quo_r;
            rem_r <= neg_dividend ? -rem_r : rem_r;
          end
          state <= S_DONE;
        end
        S_DONE: begin
          if (!done) begin
            quotient    <= quo_r;
            remainder   <= rem_r;
            div_by_zero <= dvz;
            done        <= 1'b1;
          end else begin
            done  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected results computed
// with plain 64-bit arithmetic; a negedge monitor pops and compares on done.
module tb_div_unit;

  localparam int W = 32;
  localparam int LATENCY = W + 2;

  logic          clk;
  logic          rst;
  logic          start;
  logic          is_signed;
  logic [W-1:0]  dividend;
  logic [W-1:0]  divisor;
  logic          busy;
  logic          done;
  logic [W-1:0]  quotient;
  logic [W-1:0]  remainder;
  logic          div_by_zero;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dvz;
    int           accept;
    string        tag;
  } exp_t;

  exp_t sb[$];
  int   cycle = 0;
  int   checks = 0;
  int   passes = 0;
  int   busy_drops = 0;

  div_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_signed  (is_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic failNow(input string name);
    checks++;
    $display("[TB] FAIL %s: event did not occur as required", name);
  endtask

  // Truncating division on sign- or zero-extended 64-bit values.
  function automatic exp_t ref_model(input bit sgn, input logic [W-1:0] a,
                                     input logic [W-1:0] b, input int acc, input string tag);
    exp_t e;
    longint na, nb;
    e.accept = acc;
    e.tag = tag;
    if (b == '0) begin
      e.q = '1;
      e.r = a;
      e.dvz = 1'b1;
    end else begin
      if (sgn) begin
        na = {{32{a[W-1]}}, a};
        nb = {{32{b[W-1]}}, b};
      end else begin
        na = {32'd0, a};
        nb = {32'd0, b};
      end
      e.q = W'(na / nb);
      e.r = W'(na % nb);
      e.dvz = 1'b0;
    end
    return e;
  endfunction

  task automatic applyStimulus(input string tag, input bit sgn, input logic [W-1:0] a,
                               input logic [W-1:0] b, input bit expect_result);
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) failNow({tag, "_idle_timeout"});
    start = 1'b1;
    is_signed = sgn;
    dividend = a;
    divisor = b;
    if (expect_result) sb.push_back(ref_model(sgn, a, b, cycle + 1, tag));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      failNow({tag, "_drain_timeout"});
      sb.delete();
    end
  endtask

  function automatic logic [W-1:0] pick_operand(input bit allow_zero);
    case ($urandom_range(0, 6))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return W'($urandom_range(1, 50));
      3: return allow_zero ? '0 : 32'd3;
      4: return -W'($urandom_range(1, 50));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: busy must stay high for an outstanding operation, every done
  // must match the oldest expectation and arrive exactly LATENCY cycles late.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (sb.size() != 0 && cycle >= sb[0].accept && !busy) busy_drops++;
      if (done) begin
        if (sb.size() == 0) begin
          failNow("spurious_done");
        end else begin
          e = sb.pop_front();
          checkOutput({e.tag, "_quotient"}, quotient, e.q);
          checkOutput({e.tag, "_remainder"}, remainder, e.r);
          checkOutput({e.tag, "_div_by_zero"}, W'(div_by_zero), W'(e.dvz));
          checkOutput({e.tag, "_latency"}, W'(cycle - e.accept), W'(LATENCY));
          checkOutput({e.tag, "_busy_drops"}, W'(busy_drops), '0);
          busy_drops = 0;
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    is_signed = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", W'(busy), '0);
    checkOutput("reset_done", W'(done), '0);
    checkOutput("reset_quotient", quotient, '0);
    checkOutput("reset_remainder", remainder, '0);
    checkOutput("reset_dvz", W'(div_by_zero), '0);
    rst = 1'b0;

    applyStimulus("u100_7", 1'b0, 32'd100, 32'd7, 1'b1);
    applyStimulus("s-7_2", 1'b1, -32'd7, 32'd2, 1'b1);
    applyStimulus("s7_-2", 1'b1, 32'd7, -32'd2, 1'b1);
    applyStimulus("s_dz", 1'b1, 32'h1234_5678, 32'd0, 1'b1);
    applyStimulus("u_dz", 1'b0, 32'h1234_5678, 32'd0, 1'b1);
    applyStimulus("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    applyStimulus("u_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    drain("directed");

    applyStimulus("ign", 1'b0, 32'd100, 32'd7, 1'b1);
    repeat (9) @(negedge clk);
    start = 1'b1;
    is_signed = 1'b1;
    dividend = 32'd55;
    divisor = 32'd3;
    @(negedge clk);
    start = 1'b0;
    drain("ignored_start");
    repeat (4) @(negedge clk);

    applyStimulus("aborted", 1'b0, 32'd100, 32'd7, 1'b0);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", W'(busy), '0);
    checkOutput("abort_done", W'(done), '0);
    checkOutput("abort_quotient", quotient, '0);
    checkOutput("abort_remainder", remainder, '0);
    checkOutput("abort_dvz", W'(div_by_zero), '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    applyStimulus("u9_4", 1'b0, 32'd9, 32'd4, 1'b1);

    for (int i = 0; i < 40; i++) begin
      applyStimulus($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)),
                    pick_operand(1'b0), pick_operand(1'b1), 1'b1);
    end
    drain("random");
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
